// File: rtl/fib_stack_if.sv
// Strobe/status bundle between the Fibonacci controller (master) and its stack datapath (slave).
interface fib_stack_if #(
    parameter int unsigned N_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [N_WIDTH-1:0]    n_in;
    logic                  push;
    logic                  pop;
    logic                  ins;
    logic                  mode;
    logic                  clr;
    logic                  countUp;
    logic                  empty;
    logic                  full;
    logic                  lt;
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output n_in, push, pop, ins, mode, clr, countUp,
        input  empty, full, lt, top, result, overflow, underflow
    );

    modport slave (
        input  n_in, push, pop, ins, mode, clr, countUp,
        output empty, full, lt, top, result, overflow, underflow
    );
endinterface

// File: rtl/fib_stack_datapath.sv
// Stack datapath for the recursive Fibonacci engine: sub-problem stack, work register
// and leaf-count accumulator; flags steer the upstream controller.
module fib_stack_datapath #(
    parameter int unsigned N_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 32
) (
    input  logic        clk,
    input  logic        CLR,
    fib_stack_if.slave  bus
);
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]       sp;
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic [SP_W-1:0]       sp_m1;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      push_idx;
    logic                  is_empty;
    logic                  is_full;
    logic [DATA_WIDTH-1:0] top_c;
    logic [DATA_WIDTH-1:0] pv;
    logic                  do_pop;
    logic                  do_push;
    logic                  do_repl;

    // Flags, top of stack, push value and operation decode
    always_comb begin
        is_empty = (sp == '0);
        is_full  = (sp == SP_W'(DEPTH));
        sp_m1    = sp - SP_W'(1);
        top_idx  = IDX_W'(sp_m1);
        push_idx = IDX_W'(sp);
        top_c    = is_empty ? '0 : mem[top_idx];
        if (bus.ins)
            pv = DATA_WIDTH'(bus.n_in);
        else if (bus.mode)
            pv = w - DATA_WIDTH'(1);
        else
            pv = w - DATA_WIDTH'(2);
        do_pop  = !bus.clr &&  bus.pop && !bus.push && !is_empty;
        do_push = !bus.clr && !bus.pop &&  bus.push && !is_full;
        do_repl = !bus.clr &&  bus.pop &&  bus.push && !is_empty;
    end

    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.lt        = !is_empty && (top_c < DATA_WIDTH'(2));
    assign bus.top       = top_c;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Stack storage; contents are don't-care while the pointer is below them
    always_ff @(posedge clk) begin
        if (bus.clr) begin
            if (bus.push && bus.ins)
                mem[IDX_W'(0)] <= pv;
        end else if (do_repl) begin
            mem[top_idx] <= pv;
        end else if (do_push) begin
            mem[push_idx] <= pv;
        end
    end

    // Pointer, work register, accumulator and sticky error flags
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            sp          <= '0;
            w           <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clr) begin
            sp          <= (bus.push && bus.ins) ? SP_W'(1) : '0;
            w           <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_pop || do_repl)
                w <= top_c;
            if (do_pop)
                sp <= sp_m1;
            else if (do_push)
                sp <= sp + SP_W'(1);
            if (bus.pop && is_empty)
                underflow_q <= 1'b1;
            if (bus.push && !bus.pop && is_full)
                overflow_q <= 1'b1;
            if (bus.countUp)
                result_q <= result_q + DATA_WIDTH'(top_c[0]);
        end
    end
endmodule

// File: tb/tb_fib_stack_datapath.sv
// Directed bench for fib_stack_datapath: full Fibonacci runs, leaves, overflow/underflow,
// replace operation and asynchronous reset. A DEPTH=4 copy shares the stimulus.
module tb_fib_stack_datapath;
    logic       clk = 1'b0;
    logic       CLR;
    logic [4:0] n_in;
    logic       push, pop, ins, mode, clr, cu;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    fib_stack_if #(.N_WIDTH(5), .DATA_WIDTH(16)) f0 ();
    fib_stack_if #(.N_WIDTH(5), .DATA_WIDTH(16)) f4 ();

    assign f0.n_in = n_in;  assign f4.n_in = n_in;
    assign f0.push = push;  assign f4.push = push;
    assign f0.pop  = pop;   assign f4.pop  = pop;
    assign f0.ins  = ins;   assign f4.ins  = ins;
    assign f0.mode = mode;  assign f4.mode = mode;
    assign f0.clr  = clr;   assign f4.clr  = clr;
    assign f0.countUp = cu; assign f4.countUp = cu;

    fib_stack_datapath #(.N_WIDTH(5), .DATA_WIDTH(16), .DEPTH(32)) u_dut (
        .clk(clk), .CLR(CLR), .bus(f0)
    );
    fib_stack_datapath #(.N_WIDTH(5), .DATA_WIDTH(16), .DEPTH(4)) u_dut4 (
        .clk(clk), .CLR(CLR), .bus(f4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given strobes, then sample 1 time unit after the edge
    task automatic cyc(input bit p, input bit po, input bit i, input bit m,
                       input bit c, input bit u, input logic [4:0] n);
        push = p; pop = po; ins = i; mode = m; clr = c; cu = u; n_in = n;
        @(posedge clk);
        #1;
        push = 0; pop = 0; ins = 0; mode = 0; clr = 0; cu = 0; n_in = '0;
    endtask

    task automatic run_fib(input logic [4:0] n, input logic [15:0] exp);
        int guard = 0;
        cyc(1, 0, 1, 0, 1, 0, n);
        while (!f0.empty && guard < 2000) begin
            guard++;
            if (f0.lt) begin
                cyc(0, 1, 0, 0, 0, 1, '0);
            end else begin
                cyc(0, 1, 0, 0, 0, 0, '0);
                cyc(1, 0, 0, 1, 0, 0, '0);
                cyc(1, 0, 0, 0, 0, 0, '0);
            end
        end
        check("fib_terminates", 32'(guard < 2000), 1);
        check("fib_result", 32'(f0.result), 32'(exp));
        check("fib_no_overflow", 32'(f0.overflow), 0);
        check("fib_no_underflow", 32'(f0.underflow), 0);
    endtask

    initial begin
        CLR = 1'b1;
        push = 0; pop = 0; ins = 0; mode = 0; clr = 0; cu = 0; n_in = '0;
        #12;
        check("rst_empty", 32'(f0.empty), 1);
        check("rst_full", 32'(f0.full), 0);
        check("rst_lt", 32'(f0.lt), 0);
        check("rst_top", 32'(f0.top), 0);
        check("rst_result", 32'(f0.result), 0);
        check("rst_empty4", 32'(f4.empty), 1);
        CLR = 1'b0;
        @(posedge clk);
        #1;

        run_fib(5'd5, 16'd5);
        run_fib(5'd10, 16'd55);

        // Single leaves n=0 and n=1
        cyc(1, 0, 1, 0, 1, 0, 5'd0);
        check("leaf0_lt", 32'(f0.lt), 1);
        cyc(0, 1, 0, 0, 0, 1, '0);
        check("leaf0_result", 32'(f0.result), 0);
        check("leaf0_empty", 32'(f0.empty), 1);
        cyc(1, 0, 1, 0, 1, 0, 5'd1);
        check("leaf1_lt", 32'(f0.lt), 1);
        cyc(0, 1, 0, 0, 0, 1, '0);
        check("leaf1_result", 32'(f0.result), 1);
        check("leaf1_empty", 32'(f0.empty), 1);

        // Overflow on the DEPTH=4 copy
        cyc(0, 0, 0, 0, 1, 0, '0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 5'(i));
            if (i == 3) check("d4_not_full3", 32'(f4.full), 0);
            if (i == 4) begin
                check("d4_full4", 32'(f4.full), 1);
                check("d4_top4", 32'(f4.top), 4);
                check("d4_no_ovf4", 32'(f4.overflow), 0);
            end
        end
        check("d4_ovf5", 32'(f4.overflow), 1);
        check("d4_full5", 32'(f4.full), 1);
        check("d4_top5", 32'(f4.top), 4);

        // Underflow: w stays 9, clr clears the sticky flag
        cyc(1, 0, 1, 0, 1, 0, 5'd9);
        cyc(0, 1, 0, 0, 0, 0, '0);
        check("unf_pre_empty", 32'(f0.empty), 1);
        check("unf_pre_flag", 32'(f0.underflow), 0);
        cyc(0, 1, 0, 0, 0, 0, '0);
        check("unf_flag", 32'(f0.underflow), 1);
        check("unf_empty", 32'(f0.empty), 1);
        cyc(1, 0, 0, 1, 0, 0, '0);
        check("unf_w_kept", 32'(f0.top), 8);
        cyc(0, 0, 0, 0, 1, 0, '0);
        check("unf_cleared", 32'(f0.underflow), 0);

        // Replace: stack [7], w=3, push+pop with w-2
        cyc(1, 0, 1, 0, 1, 0, 5'd3);
        cyc(0, 1, 0, 0, 0, 0, '0);
        cyc(1, 0, 1, 0, 0, 0, 5'd7);
        check("repl_pre_top", 32'(f0.top), 7);
        cyc(1, 1, 0, 0, 0, 0, '0);
        check("repl_top", 32'(f0.top), 1);
        check("repl_not_empty", 32'(f0.empty), 0);
        cyc(1, 0, 0, 1, 0, 0, '0);
        check("repl_w", 32'(f0.top), 6);
        cyc(0, 1, 0, 0, 0, 0, '0);
        check("repl_below", 32'(f0.top), 1);
        cyc(0, 1, 0, 0, 0, 0, '0);
        check("repl_sp", 32'(f0.empty), 1);

        // Asynchronous CLR mid-computation with sp=3, result=2
        cyc(1, 0, 1, 0, 1, 0, 5'd1);
        cyc(0, 1, 0, 0, 0, 1, '0);
        cyc(1, 0, 1, 0, 0, 0, 5'd1);
        cyc(0, 1, 0, 0, 0, 1, '0);
        cyc(1, 0, 1, 0, 0, 0, 5'd5);
        cyc(1, 0, 1, 0, 0, 0, 5'd4);
        cyc(1, 0, 1, 0, 0, 0, 5'd1);
        check("arst_pre_result", 32'(f0.result), 2);
        check("arst_pre_lt", 32'(f0.lt), 1);
        check("arst_pre_top", 32'(f0.top), 1);
        #2 CLR = 1'b1;
        #1;
        check("arst_empty", 32'(f0.empty), 1);
        check("arst_result", 32'(f0.result), 0);
        check("arst_top", 32'(f0.top), 0);
        check("arst_lt", 32'(f0.lt), 0);
        #2 CLR = 1'b0;
        @(posedge clk);
        #1;
        check("arst_hold_empty", 32'(f0.empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fib_stack_datapath.md
# fib_stack_datapath

Stack-based datapath for the recursive Fibonacci engine. It sits directly downstream of the Fibonacci controller: it consumes the controller strobes `push`, `pop`, `countUp`, `clr`, `ins` and `mode`, and returns the status flags `empty` and `lt` that steer the controller's state transitions. It holds the pending sub-problem stack, a work register and the leaf-count accumulator that becomes fib(n).

## Interface
- `N_WIDTH`, 5: width of the input argument `n_in`.
- `DATA_WIDTH`, 16: width of stack entries, work register and `result`; `DATA_WIDTH` ≥ `N_WIDTH`.
- `DEPTH`, 32: number of stack entries; must be ≥ max n for overflow-free operation.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `CLR`  in  1  asynchronous, active-high reset.
- `n_in`  in  N_WIDTH  argument n, zero-extended when pushed.
- `push`  in  1  push strobe.
- `pop`  in  1  pop strobe.
- `ins`  in  1  push source select: 1 = `n_in`, 0 = work register minus decrement.
- `mode`  in  1  decrement select when `ins`=0: 1 = minus 1, 0 = minus 2.
- `clr`  in  1  synchronous clear of stack, work register and `result`.
- `countUp`  in  1  accumulate the current top leaf into `result`.
- `empty`  out  1  stack pointer == 0.
- `full`  out  1  stack pointer == DEPTH.
- `lt`  out  1  stack non-empty and top < 2.
- `top`  out  DATA_WIDTH  current top entry; 0 when empty.
- `result`  out  DATA_WIDTH  accumulated Fibonacci value.
- `overflow`  out  1  sticky: a push was dropped because the stack was full.
- `underflow`  out  1  sticky: a pop was dropped because the stack was empty.

## Operation
- State: register-array stack `mem[0..DEPTH-1]`, pointer `sp` (0..DEPTH, width clog2(DEPTH+1)), work register `w`, `result`, two sticky flags.
- Push value `pv` = `n_in` if `ins`=1; else `w-1` if `mode`=1; else `w-2`. Subtraction wraps modulo 2^DATA_WIDTH.
- Per-cycle priority:
  - `clr`=1: `sp`←0, `w`←0, `result`←0, sticky flags ←0. If `push`=1 and `ins`=1 in the same cycle, `mem[0]`←`n_in` and `sp`←1. All other strobes are ignored.
  - `pop` only, and not empty: `w`←top, `sp`←`sp-1`.
  - `push` only, and not full: `mem[sp]`←`pv`, `sp`←`sp+1`.
  - `push` and `pop` together, and not empty: replace. `mem[sp-1]`←`pv` (pv computed from the old `w`), `w`←old top, `sp` unchanged.
  - Pop when empty: no state change except `underflow`←1. This covers a lone pop and a push+pop pair.
  - Push when full: no state change except `overflow`←1.
  - `countUp`=1 (not in a `clr` cycle): `result`←`result + top[0]`, using the pre-edge top. This is independent of, and combinable with, push/pop in the same cycle. On an empty stack it adds 0.
- Algorithm contract: pushing n, then repeatedly doing pop with countUp on a leaf (top<2), or pop→push w-1→push w-2 on a non-leaf, until `empty` leaves fib(n) in `result`.
- `result` wraps modulo 2^DATA_WIDTH; there is no saturation.

## Timing
- Reset (`CLR` high, asynchronous): `sp`=0, `w`=0, `result`=0, `overflow`=`underflow`=0. Hence `empty`=1, `full`=0, `lt`=0, `top`=0 immediately, without waiting for a clock. Asserting `CLR` mid-computation aborts the computation with the same values.
- `empty`, `full`, `lt` and `top` are combinational from registered state. They reflect an operation one cycle after the strobe edge, so the controller samples the flags in the cycle after issuing a push or pop.
- `result`, `w` and the sticky flags are registered, with one-cycle latency.
- Recursion from n needs at most n stack entries at once.

## Test plan
- Reset, then `clr`+`push`+`ins` with `n_in`=5, then drive the pop/countUp/push sequence until `empty` → `result`=5. Repeat with n=10 → `result`=55. Neither run sets a sticky flag.
- `n_in`=0 and `n_in`=1 single leaf: push, then pop with countUp → `result`=0 and `result`=1 respectively, and `lt`=1 the cycle before the pop.
- With DEPTH=4: five consecutive pushes → `full`=1 after the 4th, `overflow`=1 after the 5th, and `sp` stays 4 with `top` unchanged.
- Pop on an empty stack → `underflow`=1, `w` unchanged, `empty` stays 1. A following `clr` clears the flag.
- Stack [7], `w`=3, `push`+`pop`+`ins`=0+`mode`=0 → `top`=1, `w`=7, `sp` unchanged.
- Assert `CLR` mid-computation with `sp`=3 and `result`=2 → `empty`=1, `result`=0, `top`=0, `lt`=0 immediately, before the next clock edge.
